// File: rtl/sync_updown_counter.sv
// sync_updown_counter: parametrised synchronous up/down counter with
// modulus wrap, synchronous clamped parallel load and a registered
// terminal-count pulse (tc), asserted on every edge where the count wraps.
// Optional Gray-coded output port g is enabled by defining SYNC_CNT_GRAY_EN.
// Reset is asynchronous and active-low on rst.
// Priority is rst > load > t.
module sync_updown_counter #(
    parameter int WIDTH     = 3,
    parameter int MODULUS   = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
`ifdef SYNC_CNT_GRAY_EN
    ,
    output logic [WIDTH-1:0] g
`endif
);

    // Reject parameter sets the counter cannot represent.
    if ((WIDTH < 1) || (MODULUS < 2) ||
        (longint'(MODULUS) > (longint'(1) << WIDTH)) ||
        (RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_param_check
        $error("sync_updown_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   step_ext;

    // Next count and wrap pulse; arithmetic is one bit wider than the count so
    // the carry/borrow is visible when MODULUS equals 2^WIDTH.
    always_comb begin
        q_d      = q_q;
        tc_d     = 1'b0;
        q_ext    = {1'b0, q_q};
        d_ext    = {1'b0, d};
        step_ext = '0;
        if (load) begin
            if (d_ext > MAX_EXT) begin
                q_d = MAX_EXT[WIDTH-1:0];
            end else begin
                q_d = d;
            end
        end else if (t) begin
            if (up) begin
                step_ext = q_ext + ONE_EXT;
                if (step_ext > MAX_EXT) begin
                    q_d  = '0;
                    tc_d = 1'b1;
                end else begin
                    q_d = step_ext[WIDTH-1:0];
                end
            end else begin
                step_ext = q_ext - ONE_EXT;
                if (step_ext[WIDTH]) begin
                    q_d  = MAX_EXT[WIDTH-1:0];
                    tc_d = 1'b1;
                end else begin
                    q_d = step_ext[WIDTH-1:0];
                end
            end
        end
    end

    // Count and terminal-count registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q  <= RESET_Q;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

`ifdef SYNC_CNT_GRAY_EN
    localparam logic [WIDTH-1:0] RESET_G = RESET_Q ^ (RESET_Q >> 1);

    logic [WIDTH-1:0] g_q, g_d;

    // Gray code of the next count, so g is registered on the same edge as q.
    always_comb begin
        g_d = q_d ^ (q_d >> 1);
    end

    // Gray output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_q <= RESET_G;
        end else begin
            g_q <= g_d;
        end
    end

    assign g = g_q;
`endif

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: four instances share one stimulus stream,
// a modular-arithmetic model predicts each, plus directed literal checks.
module tb_sync_updown_counter;

    localparam int NI = 4;
    localparam int MODS [NI] = '{8, 6, 2, 8};
    localparam int RVS  [NI] = '{0, 0, 0, 5};
    localparam int WIDS [NI] = '{3, 3, 1, 3};

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       t    = 1'b0;
    logic       up   = 1'b1;
    logic       load = 1'b0;
    logic [2:0] d    = '0;

    logic [2:0] qa, qb, qd;
    logic [0:0] qc;
    logic       tca, tcb, tcc, tcd;
`ifdef SYNC_CNT_GRAY_EN
    logic [2:0] ga, gb, gd;
    logic [0:0] gc;
`endif

    int checks   = 0;
    int failures = 0;
    int mq  [NI];
    int mtc [NI];

    sync_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .t(t), .up(up), .load(load), .d(d),
        .q(qa), .tc(tca)
`ifdef SYNC_CNT_GRAY_EN
        , .g(ga)
`endif
    );

    sync_updown_counter #(.WIDTH(3), .MODULUS(6), .RESET_VAL(0)) dut_b (
        .clk(clk), .rst(rst), .t(t), .up(up), .load(load), .d(d),
        .q(qb), .tc(tcb)
`ifdef SYNC_CNT_GRAY_EN
        , .g(gb)
`endif
    );

    sync_updown_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(0)) dut_c (
        .clk(clk), .rst(rst), .t(t), .up(up), .load(load), .d(d[0:0]),
        .q(qc), .tc(tcc)
`ifdef SYNC_CNT_GRAY_EN
        , .g(gc)
`endif
    );

    sync_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) dut_d (
        .clk(clk), .rst(rst), .t(t), .up(up), .load(load), .d(d),
        .q(qd), .tc(tcd)
`ifdef SYNC_CNT_GRAY_EN
        , .g(gd)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int load_val(input int dv, input int w, input int m);
        int v;
        v = dv % (1 << w);
        return (v >= m) ? m - 1 : v;
    endfunction

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    // Reference model: plain modular counting per instance.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                mq[i]  <= RVS[i];
                mtc[i] <= 0;
            end else if (load) begin
                mq[i]  <= load_val(int'(d), WIDS[i], MODS[i]);
                mtc[i] <= 0;
            end else if (t && up) begin
                mq[i]  <= (mq[i] + 1) % MODS[i];
                mtc[i] <= (mq[i] + 1 == MODS[i]) ? 1 : 0;
            end else if (t) begin
                mq[i]  <= (mq[i] + MODS[i] - 1) % MODS[i];
                mtc[i] <= (mq[i] == 0) ? 1 : 0;
            end else begin
                mtc[i] <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_a_q", int'(qa), mq[0]);  chk("cmp_a_tc", int'(tca), mtc[0]);
        chk("cmp_b_q", int'(qb), mq[1]);  chk("cmp_b_tc", int'(tcb), mtc[1]);
        chk("cmp_c_q", int'(qc), mq[2]);  chk("cmp_c_tc", int'(tcc), mtc[2]);
        chk("cmp_d_q", int'(qd), mq[3]);  chk("cmp_d_tc", int'(tcd), mtc[3]);
`ifdef SYNC_CNT_GRAY_EN
        chk("cmp_a_g", int'(ga), gray(mq[0]));
        chk("cmp_b_g", int'(gb), gray(mq[1]));
        chk("cmp_c_g", int'(gc), gray(mq[2]));
        chk("cmp_d_g", int'(gd), gray(mq[3]));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_up    [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        int exp_up_tc [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int exp_dn    [7]  = '{5, 4, 3, 2, 1, 0, 5};
        int exp_dn_tc [7]  = '{1, 0, 0, 0, 0, 0, 1};
        int exp_tog   [4]  = '{3, 2, 3, 2};
        int exp_full  [8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
        int exp_gray  [8]  = '{1, 3, 2, 6, 7, 5, 4, 0};
        int prev_g;

        t = 1'b1; up = 1'b1; load = 1'b0; d = '0; rst = 1'b0;
        prev_g = 0;

        // Reset held: reset values
        #11;
        chk("rst_a_q", int'(qa), 0);
        chk("rst_a_tc", int'(tca), 0);
        chk("rst_d_q", int'(qd), 5);
        #1 rst = 1'b1;

        // Count up modulo 8
        for (int i = 0; i < 10; i++) begin
            step();
            chk("up_a_q", int'(qa), exp_up[i]);
            chk("up_a_tc", int'(tca), exp_up_tc[i]);
        end

        // Load 0 with t=1 (t ignored), then count down modulo 6
        load = 1'b1; d = 3'd0;
        step();
        chk("ld0_b_q", int'(qb), 0);
        chk("ld0_b_tc", int'(tcb), 0);
        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("dn_b_q", int'(qb), exp_dn[i]);
            chk("dn_b_tc", int'(tcb), exp_dn_tc[i]);
        end

        // Load priority and clamp
        load = 1'b1; up = 1'b1; d = 3'd3;
        step();
        chk("ld3_a_q", int'(qa), 3);
        chk("ld3_a_tc", int'(tca), 0);
        chk("ld3_b_q", int'(qb), 3);
        d = 3'd7;
        step();
        chk("clamp_b_q", int'(qb), 5);
        chk("clamp_b_tc", int'(tcb), 0);
        chk("ld7_a_q", int'(qa), 7);
        chk("ld7_a_tc", int'(tca), 0);

        // Hold, then direction toggling
        d = 3'd2;
        step();
        chk("ld2_a_q", int'(qa), 2);
        load = 1'b0; t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_a_q", int'(qa), 2);
            chk("hold_a_tc", int'(tca), 0);
        end
        t = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            step();
            chk("tog_a_q", int'(qa), exp_tog[i]);
        end

        // Asynchronous reset mid-count at q=4
        up = 1'b1;
        step();
        step();
        chk("pre_rst_a_q", int'(qa), 4);
        #2 rst = 1'b0;
        #1;
        chk("arst_a_q", int'(qa), 0);
        chk("arst_a_tc", int'(tca), 0);
        chk("arst_d_q", int'(qd), 5);
        chk("arst_c_tc", int'(tcc), 0);
        step();
        chk("arst_hold_a_q", int'(qa), 0);
        #2 rst = 1'b1;
        step();
        chk("resume_a_q", int'(qa), 1);
        chk("resume_d_q", int'(qd), 6);

        // Full up cycle from 0 (Gray sequence when enabled)
        load = 1'b1; d = 3'd0;
        step();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("full_a_q", int'(qa), exp_full[i]);
`ifdef SYNC_CNT_GRAY_EN
            chk("gray_a_g", int'(ga), exp_gray[i]);
            chk("gray_onebit", $countones(ga ^ 3'(prev_g)), 1);
            prev_g = int'(ga);
`else
            prev_g = exp_gray[i];
`endif
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Parametrised synchronous up/down counter that generalises the team's 3-bit T-enabled counter. It adds configurable width and modulus, direction control, synchronous parallel load, and a registered terminal-count pulse. An optional Gray-coded output is available. It is the standard counter primitive for timers, dividers and address generators in the synchronous-counter library.

## Interface
- WIDTH, 3, counter width in bits (≥1)
- MODULUS, 8, count range 0..MODULUS-1; legal 2 ≤ MODULUS ≤ 2^WIDTH
- RESET_VAL, 0, value of q after reset; must be < MODULUS

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- t  in  1  count enable (1 = step one position per clock)
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous parallel load strobe
- d  in  WIDTH  load value
- q  out  WIDTH  registered count
- tc  out  1  registered terminal-count pulse, one cycle per wrap
- g  out  WIDTH  registered Gray-coded count (only with SYNC_CNT_GRAY_EN)

## Operation
- **Priority:** rst > load > t. With t=0 and load=0, q holds its value and tc=0.
- **Reset:** rst=0 immediately forces q=RESET_VAL, tc=0 and g=gray(RESET_VAL), independent of clk. Release is sampled at the next rising edge. Reset mid-count discards the count and any pending tc.
- **Load:** load=1 sets q=d on the edge.
  - If d ≥ MODULUS, q=MODULUS-1 (clamped).
  - tc=0 on a load edge, even if the loaded value is 0 or MODULUS-1.
  - t and up are ignored on that edge.
- **Count up:** t=1 and up=1.
  - q<MODULUS-1 → q+1.
  - q=MODULUS-1 → 0, and tc=1 for that one cycle.
- **Count down:** t=1 and up=0.
  - q>0 → q-1.
  - q=0 → MODULUS-1, and tc=1 for that one cycle.
- **Direction change:** up may change on any cycle. The next edge uses the new direction. There is no extra latency and no glitch on q.
- **Arithmetic:** all next-state arithmetic is WIDTH+1 bits internally, truncated to WIDTH. When MODULUS=2^WIDTH, wrap equals natural overflow.
- **Terminal count:** tc is asserted only on an edge where a wrap occurs. Consecutive wraps (e.g. MODULUS=2 counting continuously) give tc high on every wrap edge.
- **Illegal parameters:** an illegal MODULUS or RESET_VAL halts elaboration with an error.

## Timing
- Single clock domain. All outputs are registered and change only on a rising clk edge, or asynchronously on rst assertion.
- Latency is one cycle from the t, load or up sample to the q, tc and g update.
- No combinational path from any input to any output.
- tc is coincident with the wrapped q value. It is never high for two cycles unless two wraps occur on consecutive edges.
- Inputs must meet setup/hold to clk. The rst deassertion edge must meet recovery/removal; the bench deasserts reset ≥2 time units away from any clk edge.

## Configuration
- Macro: SYNC_CNT_GRAY_EN.
- **Defined:** port g exists and is registered on the same edge as q, with g = q ^ (q >> 1) every cycle.
  - When MODULUS=2^WIDTH, successive g values differ in exactly one bit.
  - When MODULUS<2^WIDTH, the wrap transition may change several bits. This is documented behaviour, not an error.
- **Undefined:** port g and its register are absent. All other behaviour is identical.

## Test plan
- **Reset and count up:** WIDTH=3, MODULUS=8, RESET_VAL=0. rst=0 for 12 time units, then t=1, up=1 for 10 edges → q runs 1..7,0,1,2. tc=1 only in the cycle q=0.
- **Modulus and down-count:** MODULUS=6, t=1, up=0 from q=0 → q=5,4,3,2,1,0,5. tc=1 in the first cycle q=5 and again at the final 5.
- **Load priority and clamp:** load=1, d=3 with t=1 → q=3, tc=0. Then load=1, d=7 with MODULUS=6 → q=5, tc=0.
- **Hold and direction change:** t=0 for 4 edges → q unchanged and tc=0. Then toggle up on alternate cycles from q=2 → q=3,2,3,2.
- **Async reset mid-count:** assert rst=0 between edges at q=4 → q=RESET_VAL immediately, tc=0, with no clock edge required. On release, counting resumes from RESET_VAL.
- **Gray output (SYNC_CNT_GRAY_EN):** WIDTH=3, MODULUS=8, full up-count cycle → g sequence is 000,001,011,010,110,111,101,100,000. Exactly one bit changes per step.
